mem_sram_controller: RTL
========================

// Module: mem_sram_controller
// PURPOSE
//  MEM-stage consumer of EXE results: turns ALU_Res (address) and Val_Rm (store data) into 32-bit
//  accesses on an external 16-bit async SRAM, two half-word phases per word. Sits behind the
//  EXE/MEM register; drives ready low to freeze the pipeline until the access finishes.
// PARAMETERS
//  DATA_BASE    1024  byte address mapped to SRAM word 0
//  SRAM_ADDR_W  18    SRAM half-word address width
//  WAIT_CYCLES  2     clock cycles per half-word phase (>=1)
// PORTS
//  clk           in   1            rising-edge clock
//  rst           in   1            synchronous, active-high reset
//  MEM_R_EN      in   1            load request (held stable while ready=0)
//  MEM_W_EN      in   1            store request (held stable while ready=0)
//  ALU_Res       in   32           byte address from EXE
//  Val_Rm        in   32           store data
//  mem_data_out  out  32           load result
//  ready         out  1            1 = MEM stage may advance this cycle
//  SRAM_ADDR     out  SRAM_ADDR_W  half-word address
//  SRAM_DQ_out   out  16           write data to pad
//  SRAM_DQ_in    in   16           read data from pad
//  SRAM_DQ_oe    out  1            1 = drive SRAM_DQ_out onto the bus
//  SRAM_WE_N     out  1            active-low write enable
// BEHAVIOUR
//  - Reset: state IDLE; mem_data_out=0, SRAM_ADDR=0, SRAM_DQ_out=0, SRAM_DQ_oe=0, SRAM_WE_N=1,
//    phase counter=0. Reset mid-access aborts it immediately; no partial-word retry.
//  - word = (ALU_Res - DATA_BASE) >> 2, modulo 2^32; ALU_Res[1:0] ignored; bits above
//    SRAM_ADDR_W-1 dropped. Phase address = {word[SRAM_ADDR_W-2:0], half}; half=0 low, 1 high.
//  - Request: req = MEM_R_EN | MEM_W_EN. Both set -> write.
//  - FSM: IDLE -> LOW (if req) -> HIGH -> DONE -> IDLE.
//    LOW/HIGH each last exactly WAIT_CYCLES cycles (counter 0..WAIT_CYCLES-1); DONE lasts 1.
//  - ready (combinational) = (IDLE & ~req) | DONE. ready=0 in the request cycle in IDLE, so
//    total freeze = 1 + 2*WAIT_CYCLES cycles; ready=1 for exactly one cycle in DONE.
//  - SRAM_ADDR/SRAM_DQ_out/SRAM_DQ_oe/SRAM_WE_N are registered, loaded on each phase entry,
//    constant for the whole phase. Write: WE_N=0, oe=1 in LOW (Val_Rm[15:0]) and HIGH
//    (Val_Rm[31:16]); WE_N=1, oe=0 in IDLE/DONE. Read: WE_N=1, oe=0 throughout.
//  - Read: SRAM_DQ_in sampled on the last cycle of each phase into the low/high halves.
//    mem_data_out is loaded on the HIGH->DONE edge, valid in DONE, and held until the next read
//    completes. Writes leave mem_data_out unchanged.
//  - Requests are sampled only in IDLE. Input changes during LOW/HIGH are a protocol violation
//    and do not alter the access in flight. A new request the cycle after DONE starts a fresh
//    access, no gap cycle.
// CONFIGURATION
//  SRAM_READ_BUF_EN defined: one-entry read buffer (valid, word tag, 32-bit data).
//  - Read in IDLE with valid & tag==word is a hit: ready=1 the same cycle,
//    mem_data_out = buffer data combinationally, no SRAM cycle, FSM stays in IDLE.
//  - Miss: normal access; the buffer is filled on the HIGH->DONE edge.
//  - Completed write whose word matches tag: buffer data <= Val_Rm. rst clears valid.
//  Undefined: no buffer; every read takes the full SRAM access.
// TESTING
//  1 Idle, R=W=0 -> ready=1, SRAM_WE_N=1, SRAM_DQ_oe=0 every cycle.
//  2 Write ALU_Res=1032, Val_Rm=0xDEADBEEF, WAIT_CYCLES=2 -> cycles 1-2 ADDR=4, DQ_out=0xBEEF;
//    cycles 3-4 ADDR=5, DQ_out=0xDEAD; WE_N=0 in cycles 1-4; ready=0 in cycles 0-4, 1 in cycle 5.
//  3 Read ALU_Res=1032 against an SRAM model holding test 2 data -> mem_data_out=0xDEADBEEF
//    with ready=1 in cycle 5, held through later writes.
//  4 R=W=1, ALU_Res=1024, Val_Rm=0x12345678 -> write performed; ADDR 0 then 1, data 0x5678 then 0x1234.
//  5 rst=1 during HIGH of a write -> next cycle IDLE, WE_N=1, oe=0; with req=0, ready=1.
//  6 SRAM_READ_BUF_EN: re-read 1032 -> ready=1 in cycle 0, no SRAM activity, data 0xDEADBEEF;
//    write 0xCAFEF00D to 1032, then read -> hit returns 0xCAFEF00D.

Source files
------------

// File: rtl/mem_sram_controller.sv
// mem_sram_controller: MEM-stage 32-bit access engine for a 16-bit async SRAM.
// Each word takes two half-word phases (low then high) of WAIT_CYCLES each.
// ready drops to stall the pipeline until the access completes.
// Optional one-entry read buffer: define SRAM_READ_BUF_EN.
module mem_sram_controller #(
    parameter int DATA_BASE   = 1024,
    parameter int SRAM_ADDR_W = 18,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   MEM_R_EN,
    input  logic                   MEM_W_EN,
    input  logic [31:0]            ALU_Res,
    input  logic [31:0]            Val_Rm,
    output logic [31:0]            mem_data_out,
    output logic                   ready,
    output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
    output logic [15:0]            SRAM_DQ_out,
    input  logic [15:0]            SRAM_DQ_in,
    output logic                   SRAM_DQ_oe,
    output logic                   SRAM_WE_N
);

    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

    state_t                 state, state_nxt;
    logic [CW-1:0]          cnt;
    logic [31:0]            word;
    logic                   req, hit, start, phase_last;
    logic                   is_wr;
    logic [SRAM_ADDR_W-2:0] wq;
    logic [15:0]            wr_hi, rd_lo;
    logic [31:0]            rd_data;
    logic                   unused_bits;

    // Word index relative to the SRAM window; wraps modulo 2^32 below DATA_BASE.
    assign word        = (ALU_Res - 32'(DATA_BASE)) >> 2;
    assign unused_bits = ^word[31:SRAM_ADDR_W-1];
    assign req         = MEM_R_EN | MEM_W_EN;
    assign phase_last  = (cnt == CW'(WAIT_CYCLES - 1));
    assign start       = req & ~hit;

`ifdef SRAM_READ_BUF_EN
    logic        buf_valid;
    logic [29:0] buf_tag, lat_tag;
    logic [31:0] buf_data, lat_data;

    assign hit          = (state == IDLE) & MEM_R_EN & ~MEM_W_EN & buf_valid &
                          (buf_tag == word[29:0]);
    assign mem_data_out = hit ? buf_data : rd_data;

    // Read buffer: filled by completed reads, kept coherent by completed writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_valid <= 1'b0;
            buf_tag   <= '0;
            buf_data  <= '0;
            lat_tag   <= '0;
            lat_data  <= '0;
        end else begin
            if (state == IDLE && start) begin
                lat_tag  <= word[29:0];
                lat_data <= Val_Rm;
            end
            if (state == HIGH && phase_last) begin
                if (!is_wr) begin
                    buf_valid <= 1'b1;
                    buf_tag   <= lat_tag;
                    buf_data  <= {SRAM_DQ_in, rd_lo};
                end else if (buf_valid && buf_tag == lat_tag) begin
                    buf_data <= lat_data;
                end
            end
        end
    end
`else
    assign hit          = 1'b0;
    assign mem_data_out = rd_data;
`endif

    // Pipeline may advance when idle with nothing to do (or buffer hit), or in DONE.
    assign ready = ((state == IDLE) & ~start) | (state == DONE);

    // Next-state logic: each half-word phase lasts WAIT_CYCLES, DONE lasts one cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = LOW;
            LOW:     if (phase_last) state_nxt = HIGH;
            HIGH:    if (phase_last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register and phase cycle counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if ((state == LOW || state == HIGH) && !phase_last)
                cnt <= cnt + 1'b1;
            else
                cnt <= '0;
        end
    end

    // SRAM pins are loaded on phase entry and held for the phase; read halves
    // are captured on the last cycle of each phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            SRAM_ADDR   <= '0;
            SRAM_DQ_out <= '0;
            SRAM_DQ_oe  <= 1'b0;
            SRAM_WE_N   <= 1'b1;
            rd_data     <= '0;
            rd_lo       <= '0;
            is_wr       <= 1'b0;
            wq          <= '0;
            wr_hi       <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    is_wr       <= MEM_W_EN;
                    wq          <= word[SRAM_ADDR_W-2:0];
                    wr_hi       <= Val_Rm[31:16];
                    SRAM_ADDR   <= {word[SRAM_ADDR_W-2:0], 1'b0};
                    SRAM_DQ_out <= Val_Rm[15:0];
                    SRAM_DQ_oe  <= MEM_W_EN;
                    SRAM_WE_N   <= ~MEM_W_EN;
                end
                LOW: if (phase_last) begin
                    rd_lo       <= SRAM_DQ_in;
                    SRAM_ADDR   <= {wq, 1'b1};
                    SRAM_DQ_out <= wr_hi;
                end
                HIGH: if (phase_last) begin
                    SRAM_DQ_oe <= 1'b0;
                    SRAM_WE_N  <= 1'b1;
                    if (!is_wr) rd_data <= {SRAM_DQ_in, rd_lo};
                end
                default: ;
            endcase
        end
    end

endmodule
